// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one 64-bit data memory
// between the pipeline MEM stage (port 0) and a loader/debug port (port 1).
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              r_write;
  logic              r_err;
  logic              winner;
  logic              accept;
  logic              sel_write;
  logic              sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Handshake: a request transfers on a rising edge where reqN_valid and
  // reqN_ready are both high; the requester holds its fields until then and
  // may drop valid beforehand without anything being accepted.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant;
    else if (req1_valid)          winner = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !winner;
  assign req1_ready = (state == IDLE) && req1_valid &&  winner;
  assign accept     = req0_ready || req1_ready;

  assign sel_write = winner ? req1_write : req0_write;
  assign sel_addr  = winner ? req1_addr  : req0_addr;
  assign sel_wdata = winner ? req1_wdata : req0_wdata;
  // No wrap-around: anything past the last full 8-byte word is trapped.
  assign sel_err   = sel_addr > LAST_ADDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      r_write       <= 1'b0;
      r_err         <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_MemRead   <= 1'b0;
      mem_MemWrite  <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp0_rdata    <= '0;
      rsp0_err      <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp1_rdata    <= '0;
      rsp1_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner         <= winner;
            last_grant    <= winner;
            r_write       <= sel_write;
            r_err         <= sel_err;
            mem_address   <= sel_addr;
            mem_writeData <= sel_wdata;
            mem_MemRead   <= !sel_write && !sel_err;
            mem_MemWrite  <= sel_write && !sel_err;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          mem_MemRead  <= 1'b0;
          mem_MemWrite <= 1'b0;
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_err   <= r_err;
            rsp1_rdata <= (!r_write && !r_err) ? mem_readData : '0;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_err   <= r_err;
            rsp0_rdata <= (!r_write && !r_err) ? mem_readData : '0;
          end
          state <= RESP;
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp0_rdata <= '0;
          rsp0_err   <= 1'b0;
          rsp1_valid <= 1'b0;
          rsp1_rdata <= '0;
          rsp1_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
